md5_pad: RTL and testbench

- Message padder between the keyboard/ASCII capture path and the MD5 compression core (md5update).
- Accepts a byte stream plus an end-of-message strobe and emits 512-bit blocks over a valid/ready handshake.
- Appends the 0x80 marker, zero fill and the 64-bit little-endian bit length, issuing a second block when the length does not fit.
- Replaces the ad-hoc padding inside the display controller; the display controller only forwards typed characters and Enter.

---
 rtl/md5_pad.sv | 119 +++++++++++
 tb/tb_md5_pad.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_pad.sv
// MD5 message padder: packs a byte stream into 512-bit blocks, appends the 0x80 marker,
// zero fill and the 64-bit little-endian bit length, adding a second block when needed.
module md5_pad #(
    parameter int unsigned BYTE_CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    input  logic         msg_end,
    output logic         byte_ready,
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         blk_last,
    input  logic         blk_ready,
    output logic         busy
);

    typedef enum logic [1:0] {StFill, StSend, StExtra} state_e;

    state_e                state;
    logic [5:0]            idx;
    logic [BYTE_CNT_W-1:0] total;
    logic [511:0]          buffer;
    logic                  need_extra;
    logic [63:0]           bit_len;
    logic [511:0]          end_buf;

    assign bit_len  = 64'({total, 3'b000});
    assign blk_data = buffer;

    // Current buffer with the marker at idx, zeros above it, and the length if it fits.
    always_comb begin
        end_buf = buffer;
        for (int i = 0; i < 64; i++) begin
            if (6'(i) == idx) begin
                end_buf[8*i +: 8] = 8'h80;
            end else if (6'(i) > idx) begin
                end_buf[8*i +: 8] = 8'h00;
            end
        end
        if (idx <= 6'd55) begin
            end_buf[511:448] = bit_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StFill;
            idx        <= '0;
            total      <= '0;
            buffer     <= '0;
            need_extra <= 1'b0;
            blk_last   <= 1'b0;
            busy       <= 1'b0;
            byte_ready <= 1'b1;
            blk_valid  <= 1'b0;
        end else begin
            unique case (state)
                StFill: begin
                    // A byte takes priority; a concurrent msg_end stays pending.
                    if (byte_valid) begin
                        buffer[{idx, 3'b000} +: 8] <= byte_data;
                        idx   <= idx + 6'd1;
                        total <= total + BYTE_CNT_W'(1);
                        busy  <= 1'b1;
                        if (idx == 6'd63) begin
                            blk_last   <= 1'b0;
                            byte_ready <= 1'b0;
                            blk_valid  <= 1'b1;
                            state      <= StSend;
                        end
                    end else if (msg_end) begin
                        buffer     <= end_buf;
                        busy       <= 1'b1;
                        byte_ready <= 1'b0;
                        blk_valid  <= 1'b1;
                        state      <= StSend;
                        if (idx <= 6'd55) begin
                            blk_last <= 1'b1;
                        end else begin
                            blk_last   <= 1'b0;
                            need_extra <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (blk_ready) begin
                        buffer    <= '0;
                        blk_valid <= 1'b0;
                        if (need_extra) begin
                            state <= StExtra;
                        end else begin
                            state      <= StFill;
                            byte_ready <= 1'b1;
                            if (blk_last) begin
                                total    <= '0;
                                idx      <= '0;
                                busy     <= 1'b0;
                                blk_last <= 1'b0;
                            end
                        end
                    end
                end
                StExtra: begin
                    buffer     <= {bit_len, 448'b0};
                    blk_last   <= 1'b1;
                    need_extra <= 1'b0;
                    blk_valid  <= 1'b1;
                    state      <= StSend;
                end
                default: begin
                    state <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_pad.sv
// Self-checking bench for md5_pad: table of messages plus backpressure and reset sequences.
module tb_md5_pad;

    logic         clk = 1'b0;
    logic         reset;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         msg_end;
    logic         byte_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_ready;
    logic         busy;

    always #5 clk = ~clk;

    md5_pad #(.BYTE_CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .msg_end    (msg_end),
        .byte_ready (byte_ready),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .blk_ready  (blk_ready),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [511:0] got_data[$];
    logic         got_last[$];
    int           got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change #1 after posedge, so the negedge sees a settled handshake.
    always @(negedge clk) begin
        if (reset && blk_valid && blk_ready) begin
            got_data.push_back(blk_data);
            got_last.push_back(blk_last);
            got_cyc.push_back(cyc);
        end
    end

    typedef struct {
        int           len;
        logic [7:0]   base;
        logic [7:0]   inc;
        int           nblk;
        logic [511:0] exp0;
        logic         last0;
        logic [511:0] exp1;
        logic         last1;
        int           gap;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [511:0] data_blk(int n, logic [7:0] base, logic [7:0] inc);
        logic [511:0] b = '0;
        for (int i = 0; i < n; i++) b[8*i +: 8] = base + 8'(i) * inc;
        return b;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!byte_ready && n < 100) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: byte_ready=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        wait_ready();
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
    endtask

    task automatic send_end();
        byte_valid = 1'b0;
        wait_ready();
        msg_end = 1'b1;
        tick();
        msg_end = 1'b0;
        check("end_to_valid", blk_valid, 1'b1);
        check("busy_after_end", busy, 1'b1);
    endtask

    task automatic wait_blocks(input int n);
        int k = 0;
        while (got_data.size() < n && k < 200) begin
            tick();
            k++;
        end
        check("blk_count", got_data.size(), n);
    endtask

    task automatic clear_q();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [511:0] b;
        logic [511:0] exp_xy;
        logic [511:0] exp_u;

        // "abc"
        b = data_blk(3, 8'h61, 8'h01);
        b[31:24] = 8'h80;
        b[511:448] = 64'h18;
        vecs[0] = '{3, 8'h61, 8'h01, 1, b, 1'b1, '0, 1'b0, 0};
        // 55 x 'A': marker in byte 55, length fits
        b = data_blk(55, 8'h41, 8'h00);
        b[447:440] = 8'h80;
        b[511:448] = 64'h1B8;
        vecs[1] = '{55, 8'h41, 8'h00, 1, b, 1'b1, '0, 1'b0, 0};
        // 56 x 'A': length spills into a second block
        b = data_blk(56, 8'h41, 8'h00);
        b[455:448] = 8'h80;
        vecs[2] = '{56, 8'h41, 8'h00, 2, b, 1'b0, {64'h1C0, 448'b0}, 1'b1, 2};
        // 64 bytes 00..3f: full block, then marker-only block
        b = data_blk(64, 8'h00, 8'h01);
        vecs[3] = '{64, 8'h00, 8'h01, 2, b, 1'b0, {64'h200, 440'b0, 8'h80}, 1'b1, 0};
        // Empty message
        vecs[4] = '{0, 8'h00, 8'h00, 1, {64'h0, 440'b0, 8'h80}, 1'b1, '0, 1'b0, 0};

        exp_xy = {64'h10, 424'b0, 8'h80, 8'h79, 8'h78};
        exp_u  = {64'h8, 432'b0, 8'h80, 8'h55};

        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        msg_end    = 1'b0;
        blk_ready  = 1'b1;
        tick();
        tick();
        check("rst_blk_valid", blk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        check("rel_byte_ready", byte_ready, 1'b1);
        check("rel_blk_valid", blk_valid, 1'b0);
        check("rel_blk_last", blk_last, 1'b0);
        check("rel_busy", busy, 1'b0);
        check("rel_blk_data", blk_data, '0);

        for (int vi = 0; vi < 5; vi++) begin
            clear_q();
            for (int i = 0; i < vecs[vi].len; i++) begin
                drive_byte(vecs[vi].base + 8'(i) * vecs[vi].inc);
                if (i == 63) begin
                    check($sformatf("v%0d_byte_to_valid", vi), blk_valid, 1'b1);
                    check($sformatf("v%0d_full_byte_ready", vi), byte_ready, 1'b0);
                end
            end
            send_end();
            wait_blocks(vecs[vi].nblk);
            tick();
            if (got_data.size() >= vecs[vi].nblk) begin
                check($sformatf("v%0d_blk0", vi), got_data[0], vecs[vi].exp0);
                check($sformatf("v%0d_last0", vi), got_last[0], vecs[vi].last0);
                if (vecs[vi].nblk == 2) begin
                    check($sformatf("v%0d_blk1", vi), got_data[1], vecs[vi].exp1);
                    check($sformatf("v%0d_last1", vi), got_last[1], vecs[vi].last1);
                end
                if (vecs[vi].gap != 0) begin
                    check($sformatf("v%0d_extra_gap", vi), got_cyc[1] - got_cyc[0],
                          vecs[vi].gap);
                end
            end
            check($sformatf("v%0d_busy_done", vi), busy, 1'b0);
        end

        // Backpressure: block held, pending byte must wait.
        clear_q();
        blk_ready = 1'b0;
        drive_byte(8'h78);
        drive_byte(8'h79);
        send_end();
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_data_%0d", i), blk_data, exp_xy);
            check($sformatf("bp_ready_%0d", i), byte_ready, 1'b0);
            check($sformatf("bp_last_%0d", i), blk_last, 1'b1);
        end
        blk_ready = 1'b1;
        tick();
        check("bp_after_hs_valid", blk_valid, 1'b0);
        tick();
        byte_valid = 1'b0;
        check("bp_count", got_data.size(), 1);
        if (got_data.size() >= 1) check("bp_blk", got_data[0], exp_xy);
        clear_q();
        send_end();
        wait_blocks(1);
        tick();
        if (got_data.size() >= 1) begin
            check("held_byte_blk", got_data[0], exp_u);
            check("held_byte_last", got_last[0], 1'b1);
        end

        // Reset while a block is pending.
        clear_q();
        blk_ready = 1'b0;
        drive_byte(8'h78);
        drive_byte(8'h79);
        send_end();
        tick();
        check("pre_rst_valid", blk_valid, 1'b1);
        reset = 1'b0;
        tick();
        check("mid_rst_valid", blk_valid, 1'b0);
        check("mid_rst_ready", byte_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        reset     = 1'b1;
        blk_ready = 1'b1;
        tick();
        check("mid_rst_no_hs", got_data.size(), 0);
        clear_q();
        drive_byte(8'h61);
        drive_byte(8'h62);
        drive_byte(8'h63);
        send_end();
        wait_blocks(1);
        tick();
        if (got_data.size() >= 1) begin
            check("post_rst_len", got_data[0][511:448], 64'h18);
            check("post_rst_blk", got_data[0], vecs[0].exp0);
        end
        check("post_rst_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
